mul_sequencer: RTL and testbench

- Multi-cycle MUL/MLA controller for the EXE stage.
- Borrows the shared 32-bit ALU and runs a shift-add multiply through it, one ADD per cycle.
- Stalls the pipeline while it owns the ALU, then returns the 32-bit product (low word) and the updated status flags.
- The ALU stays outside this block; the EXE-stage operand/command mux selects this block's drive when alu_sel=1.

---
 rtl/mul_sequencer_pkg.sv | 15 +
 rtl/mul_sequencer_if.sv | 32 +++
 rtl/mul_sequencer.sv | 96 +++++++++
 tb/tb_mul_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: state encodings, iteration count and ALU command shared by the MUL/MLA sequencer
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        MULSEQ_IDLE,
        MULSEQ_ITER,
        MULSEQ_ACC,
        MULSEQ_DONE
    } state_t;

    localparam int MULSEQ_ITERS = 32;

    localparam logic [3:0] ADD_EXE = 4'b0010;

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/result handshake and shared-ALU borrow signals of the MUL/MLA sequencer
interface mul_sequencer_if;

    logic        start;
    logic        is_mla;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] rn;
    logic [3:0]  sr_in;
    logic        flush;
    logic        alu_sel;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic        alu_cin;
    logic [3:0]  alu_exe_cmd;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  sr_out;

    modport master (
        output start, is_mla, rm, rs, rn, sr_in, flush, alu_result,
        input  alu_sel, alu_val1, alu_val2, alu_cin, alu_exe_cmd, busy, done, result, sr_out
    );

    modport slave (
        input  start, is_mla, rm, rs, rn, sr_in, flush, alu_result,
        output alu_sel, alu_val1, alu_val2, alu_cin, alu_exe_cmd, busy, done, result, sr_out
    );

endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add MUL/MLA through the shared EXE ALU; MUL_EARLY_TERM_EN stops once the multiplier runs out of set bits
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int ITER_W = 6
) (
    input logic          clk,
    input logic          rst,
    mul_sequencer_if.slave bus
);

    state_t            state, next;
    logic [31:0]       acc, mcand, mplier, rn_q, res_q;
    logic [ITER_W-1:0] count;
    logic              mla_q, last, skip, take, busy, done;
    logic [1:0]        cv_q;
    logic [3:0]        sr_o_q, sr_now;

    assign take = state == MULSEQ_IDLE && bus.start && !bus.flush;

`ifdef MUL_EARLY_TERM_EN
    assign last = count == ITER_W'(MULSEQ_ITERS - 1) || mplier[31:1] == '0;
    assign skip = bus.rs == '0;
`else
    assign last = count == ITER_W'(MULSEQ_ITERS - 1);
    assign skip = 1'b0;
`endif

    assign sr_now = {acc == '0, cv_q[1], acc[31], cv_q[0]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MULSEQ_IDLE;
        else     state <= next;
    end

    // Next-state decode and ALU/handshake drive
    always_comb begin
        next = state;
        unique case (state)
            MULSEQ_IDLE: next = take ? (skip ? (bus.is_mla ? MULSEQ_ACC : MULSEQ_DONE) : MULSEQ_ITER) : MULSEQ_IDLE;
            MULSEQ_ITER: next = last ? (mla_q ? MULSEQ_ACC : MULSEQ_DONE) : MULSEQ_ITER;
            MULSEQ_ACC:  next = MULSEQ_DONE;
            default:     next = MULSEQ_IDLE;
        endcase
        if (bus.flush) next = MULSEQ_IDLE;
        busy            = state == MULSEQ_ITER || state == MULSEQ_ACC;
        done            = state == MULSEQ_DONE && !bus.flush;
        bus.busy        = busy;
        bus.alu_sel     = busy;
        bus.alu_val1    = acc;
        bus.alu_val2    = state == MULSEQ_ACC ? rn_q : (state == MULSEQ_ITER && mplier[0]) ? mcand : '0;
        bus.alu_cin     = 1'b0;
        bus.alu_exe_cmd = ADD_EXE;
        bus.done        = done;
        bus.result      = done ? acc : res_q;
        bus.sr_out      = done ? sr_now : sr_o_q;
    end

    // Operand capture, shift-add step, accumulate and result hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rn_q   <= '0;
            mla_q  <= 1'b0;
            cv_q   <= '0;
            count  <= '0;
            res_q  <= '0;
            sr_o_q <= '0;
        end else begin
            if (take) begin
                mcand  <= bus.rm;
                mplier <= bus.rs;
                rn_q   <= bus.rn;
                mla_q  <= bus.is_mla;
                cv_q   <= {bus.sr_in[2], bus.sr_in[0]};
                acc    <= '0;
                count  <= '0;
            end
            if (state == MULSEQ_ITER) begin
                acc    <= bus.alu_result;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
            if (state == MULSEQ_ACC) acc <= bus.alu_result;
            if (done) begin
                res_q  <= acc;
                sr_o_q <= sr_now;
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed MUL/MLA vectors against an external ALU model, with flush and reset aborts
module tb_mul_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    mul_sequencer_if bus();

    mul_sequencer #(.ITER_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.alu_result = bus.alu_sel ? bus.alu_val1 + bus.alu_val2 + {31'b0, bus.alu_cin} : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic mla, input logic [31:0] rs);
        int lat;
`ifdef MUL_EARLY_TERM_EN
        int h = -1;
        for (int i = 0; i < 32; i++) if (rs[i]) h = i;
        lat = rs == 0 ? 1 : h + 2;
`else
        lat = 33;
`endif
        return lat + int'(mla);
    endfunction

    task automatic run_op(input string tag, input logic mla, input logic [31:0] rm, input logic [31:0] rs,
                          input logic [31:0] rn, input logic [3:0] sr, input logic [31:0] exp_res,
                          input logic [3:0] exp_sr);
        int n, nb, lat;
        lat = exp_lat(mla, rs);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.is_mla = mla;
        bus.rm     = rm;
        bus.rs     = rs;
        bus.rn     = rn;
        bus.sr_in  = sr;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rm    = 32'hDEAD_BEEF;
        bus.rs    = 32'hFFFF_FFFF;
        bus.rn    = 32'h1111_1111;
        bus.sr_in = ~sr;
        n  = 1;
        nb = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) nb++;
            if (n == 2) begin
                check({tag, "_cmd"}, {28'b0, bus.alu_exe_cmd}, 32'h2);
                check({tag, "_cin"}, {31'b0, bus.alu_cin}, 32'h0);
            end
            bus.start = n == 5;
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_done"}, {31'b0, bus.done}, 32'h1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_cycles"}, nb, lat - 1);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_sr_out"}, {28'b0, bus.sr_out}, {28'b0, exp_sr});
        @(posedge clk);
        #1;
        check({tag, "_held"}, bus.result, exp_res);
        check({tag, "_pulse"}, {30'b0, bus.done, bus.busy}, 32'h0);
    endtask

    initial begin
        int  lat;
        logic seen;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.is_mla = 1'b0;
        bus.rm     = '0;
        bus.rs     = '0;
        bus.rn     = '0;
        bus.sr_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_sel", {31'b0, bus.alu_sel}, 32'h0);
        check("rst_result", bus.result, 32'h0);
        check("rst_sr_out", {28'b0, bus.sr_out}, 32'h0);
        check("rst_val1", bus.alu_val1, 32'h0);
        check("rst_val2", bus.alu_val2, 32'h0);
        check("rst_cin", {31'b0, bus.alu_cin}, 32'h0);
        check("rst_cmd", {28'b0, bus.alu_exe_cmd}, 32'h2);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x6",    1'b0, 32'd7,         32'd6,         32'd0, 4'b0101, 32'd42,        4'b0101);
        run_op("mla_wrap",   1'b1, 32'hFFFF_FFFF, 32'd2,         32'd5, 4'b0000, 32'h0000_0003, 4'b0000);
        run_op("mul_neg",    1'b0, 32'h4000_0000, 32'd2,         32'd0, 4'b0000, 32'h8000_0000, 4'b0010);
        run_op("mul_zero",   1'b0, 32'h1234,      32'd0,         32'd0, 4'b0000, 32'h0,         4'b1000);
        run_op("mla_cv",     1'b1, 32'd3,         32'd3,         32'd1, 4'b1111, 32'd10,        4'b0101);
        run_op("mla_rs0",    1'b1, 32'h55,        32'd0,         32'd7, 4'b0000, 32'd7,         4'b0000);
        run_op("mul_rs1",    1'b0, 32'd9,         32'd1,         32'd0, 4'b0000, 32'd9,         4'b0000);
        run_op("mul_msb",    1'b0, 32'd1,         32'h8000_0000, 32'd0, 4'b0000, 32'h8000_0000, 4'b0010);
        run_op("mul_signed", 1'b0, 32'hFFFF_FFFF, 32'd5,         32'd0, 4'b0000, 32'hFFFF_FFFB, 4'b0010);

        @(negedge clk);
        bus.start = 1'b1;
        bus.is_mla = 1'b0;
        bus.rm = 32'd11;
        bus.rs = 32'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            bus.flush = n == 10;
            seen |= bus.done;
            if (n < 11) begin
                @(posedge clk);
                #1;
            end
        end
        check("flush_iter_nodone", {31'b0, seen}, 32'h0);
        check("flush_iter_busy", {31'b0, bus.busy}, 32'h0);
        check("flush_iter_result", bus.result, 32'hFFFF_FFFB);
        check("flush_iter_sr_out", {28'b0, bus.sr_out}, 32'h2);
        @(posedge clk);
        run_op("after_flush", 1'b0, 32'd3, 32'd3, 32'd0, 4'b0000, 32'd9, 4'b0000);

        lat = exp_lat(1'b0, 32'd2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rm = 32'd2;
        bus.rs = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n < lat; n++) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        #1;
        check("flush_done_pulse", {31'b0, bus.done}, 32'h0);
        check("flush_done_result", bus.result, 32'd9);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        #1;
        check("flush_done_after", {30'b0, bus.done, bus.busy}, 32'h0);
        check("flush_done_held", bus.result, 32'd9);

        @(negedge clk);
        bus.start = 1'b1;
        bus.rm = 32'd9;
        bus.rs = 32'h109;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", {31'b0, bus.busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
        check("mid_rst_done", {31'b0, bus.done}, 32'h0);
        check("mid_rst_result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 1'b0, 32'd5, 32'd5, 32'd0, 4'b0000, 32'd25, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
